// File: rtl/packet_split.sv
// packet_split: 512-bit to 64-bit AXI-Stream width-down converter that skips empty trailing lanes
module packet_split (
   input  logic         clk,
   input  logic         reset_n,
   output logic         o_tready_in,
   input  logic         i_tvalid_in,
   input  logic [511:0] i_tdata_in,
   input  logic [63:0]  i_tkeep_in,
   input  logic         i_tlast_in,
   input  logic         i_tready_out,
   output logic         o_tvalid_out,
   output logic [63:0]  o_tdata_out,
   output logic [7:0]   o_tkeep_out,
   output logic         o_tlast_out
);
   logic         busy_q, busy_d;
   logic [511:0] data_q, data_d;
   logic [63:0]  keep_q, keep_d;
   logic         last_q, last_d;
   logic [2:0]   idx_q, idx_d;
   logic [2:0]   lmax_q, lmax_d;
   logic [6:0]   cnt;
   logic         at_end, in_hs, out_hs;
   assign at_end       = idx_q == lmax_q;
   assign o_tready_in  = reset_n & (~busy_q | (i_tready_out & at_end));
   assign o_tvalid_out = busy_q;
   assign o_tdata_out  = data_q[{idx_q, 6'd0} +: 64];
   assign o_tkeep_out  = keep_q[{idx_q, 3'd0} +: 8];
   assign o_tlast_out  = busy_q & last_q & at_end;
   assign in_hs        = i_tvalid_in & o_tready_in;
   assign out_hs       = busy_q & i_tready_out;
   always_comb begin
      cnt = '0;
      for (int i = 0; i < 64; i++) cnt = cnt + 7'(i_tkeep_in[i]);
      busy_d = in_hs ? 1'b1 : (out_hs & at_end) ? 1'b0 : busy_q;
      idx_d  = in_hs ? 3'd0 : (out_hs & ~at_end) ? idx_q + 3'd1 : idx_q;
      data_d = in_hs ? i_tdata_in : data_q;
      keep_d = in_hs ? i_tkeep_in : keep_q;
      last_d = in_hs ? i_tlast_in : last_q;
      lmax_d = in_hs ? ((cnt == 7'd0) ? 3'd0 : 3'((cnt - 7'd1) >> 3)) : lmax_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         data_q <= '0;
         keep_q <= '0;
         last_q <= 1'b0;
         idx_q  <= '0;
         lmax_q <= '0;
      end else begin
         busy_q <= busy_d;
         data_q <= data_d;
         keep_q <= keep_d;
         last_q <= last_d;
         idx_q  <= idx_d;
         lmax_q <= lmax_d;
      end
   end
endmodule

// File: tb/tb_packet_split.sv
// tb_packet_split: directed and randomized checks of packet_split against a lane-queue reference model
module tb_packet_split;
   logic         clk = 1'b0;
   logic         reset_n;
   logic         o_tready_in;
   logic         i_tvalid_in;
   logic [511:0] i_tdata_in;
   logic [63:0]  i_tkeep_in;
   logic         i_tlast_in;
   logic         i_tready_out;
   logic         o_tvalid_out;
   logic [63:0]  o_tdata_out;
   logic [7:0]   o_tkeep_out;
   logic         o_tlast_out;

   packet_split dut (
      .clk(clk), .reset_n(reset_n), .o_tready_in(o_tready_in),
      .i_tvalid_in(i_tvalid_in), .i_tdata_in(i_tdata_in), .i_tkeep_in(i_tkeep_in),
      .i_tlast_in(i_tlast_in), .i_tready_out(i_tready_out), .o_tvalid_out(o_tvalid_out),
      .o_tdata_out(o_tdata_out), .o_tkeep_out(o_tkeep_out), .o_tlast_out(o_tlast_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;
   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      int          cyc;
   } lane_t;

   beat_t      src_q[$];
   lane_t      exp_q[$];
   lane_t      log_q[$];
   logic [7:0] in_bytes[$];
   logic [7:0] out_bytes[$];
   int checks = 0, errors = 0, cyc = 0, vpct = 100, rpct = 100, tlast_cnt = 0;
   logic hold_v = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every held beat expands into max(1, ceil(bytes/8)) lanes; tlast rides on the final lane only.
   task automatic load_model(input beat_t b);
      int n, l;
      lane_t e;
      n = $countones(b.k);
      l = (n == 0) ? 1 : (n + 7) / 8;
      for (int k = 0; k < l; k++) begin
         e.d = b.d[64*k +: 64];
         e.k = b.k[8*k +: 8];
         e.l = b.l && (k == l - 1);
         e.cyc = 0;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 64; i++) if (b.k[i]) in_bytes.push_back(b.d[8*i +: 8]);
   endtask

   task automatic step();
      logic exp_rdy, hs_in, hs_out;
      lane_t o;
      if (src_q.size() != 0) begin
         i_tvalid_in = hold_v || ($urandom_range(99) < vpct);
         i_tdata_in  = src_q[0].d;
         i_tkeep_in  = src_q[0].k;
         i_tlast_in  = src_q[0].l;
      end else i_tvalid_in = 1'b0;
      i_tready_out = $urandom_range(99) < rpct;
      #1;
      exp_rdy = (exp_q.size() == 0) || (i_tready_out && exp_q.size() == 1);
      chk("tready_in", 64'(o_tready_in), 64'(exp_rdy));
      chk("tvalid_out", 64'(o_tvalid_out), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("tdata_out", o_tdata_out, exp_q[0].d);
         chk("tkeep_out", 64'(o_tkeep_out), 64'(exp_q[0].k));
         chk("tlast_out", 64'(o_tlast_out), 64'(exp_q[0].l));
      end
      hs_out = (exp_q.size() != 0) && i_tready_out;
      hs_in  = i_tvalid_in && exp_rdy;
      hold_v = i_tvalid_in && !hs_in;
      if (hs_out) begin
         o.d = o_tdata_out; o.k = o_tkeep_out; o.l = o_tlast_out; o.cyc = cyc;
         log_q.push_back(o);
         for (int j = 0; j < 8; j++) if (o_tkeep_out[j]) out_bytes.push_back(o_tdata_out[8*j +: 8]);
         if (o_tlast_out) tlast_cnt++;
         void'(exp_q.pop_front());
      end
      if (hs_in) begin
         load_model(src_q[0]);
         void'(src_q.pop_front());
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(src_q.size() + exp_q.size()), 64'd0);
   endtask

   function automatic beat_t mk(input int nbytes, input logic last, input logic seq);
      beat_t b;
      for (int i = 0; i < 64; i++) b.d[8*i +: 8] = seq ? 8'(i) : 8'($urandom);
      b.k = (nbytes >= 64) ? '1 : ((64'd1 << nbytes) - 64'd1);
      b.l = last;
      return b;
   endfunction

   initial begin
      int n;
      reset_n = 1'b0;
      i_tvalid_in = 1'b0; i_tdata_in = '0; i_tkeep_in = '0; i_tlast_in = 1'b0; i_tready_out = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(o_tvalid_out), 64'd0);
      chk("rst_tdata", o_tdata_out, 64'd0);
      chk("rst_tkeep", 64'(o_tkeep_out), 64'd0);
      chk("rst_tlast", 64'(o_tlast_out), 64'd0);
      chk("rst_tready", 64'(o_tready_in), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // single full beat, bytes 0x00..0x3F
      log_q.delete();
      src_q.push_back(mk(64, 1'b1, 1'b1));
      run(50);
      chk("full_count", 64'(log_q.size()), 64'd8);
      if (log_q.size() == 8) begin
         chk("full_b0_data", log_q[0].d, 64'h0706050403020100);
         chk("full_b0_keep", 64'(log_q[0].k), 64'hFF);
         chk("full_b0_last", 64'(log_q[0].l), 64'd0);
         chk("full_b6_last", 64'(log_q[6].l), 64'd0);
         chk("full_b7_data", log_q[7].d, 64'h3F3E3D3C3B3A3938);
         chk("full_b7_last", 64'(log_q[7].l), 64'd1);
      end

      // two-beat packet, 64 + 13 bytes, must stream without a bubble
      log_q.delete();
      src_q.push_back(mk(64, 1'b0, 1'b0));
      src_q.push_back(mk(13, 1'b1, 1'b0));
      run(50);
      chk("two_count", 64'(log_q.size()), 64'd10);
      if (log_q.size() == 10) begin
         chk("two_b8_keep", 64'(log_q[8].k), 64'hFF);
         chk("two_b9_keep", 64'(log_q[9].k), 64'h1F);
         chk("two_b9_last", 64'(log_q[9].l), 64'd1);
         chk("two_b7_last", 64'(log_q[7].l), 64'd0);
         chk("two_contig", 64'(log_q[9].cyc - log_q[0].cyc), 64'd9);
      end

      // zero-length last beat after a full beat
      log_q.delete();
      src_q.push_back(mk(64, 1'b0, 1'b0));
      src_q.push_back(mk(0, 1'b1, 1'b0));
      run(50);
      chk("zero_count", 64'(log_q.size()), 64'd9);
      if (log_q.size() == 9) begin
         chk("zero_keep", 64'(log_q[8].k), 64'h00);
         chk("zero_last", 64'(log_q[8].l), 64'd1);
      end

      // 200 random packets with 50% sink readiness
      in_bytes.delete(); out_bytes.delete(); tlast_cnt = 0;
      vpct = 70; rpct = 50;
      for (int p = 0; p < 200; p++) begin
         n = $urandom_range(2);
         for (int b = 0; b < n; b++) src_q.push_back(mk(64, 1'b0, 1'b0));
         src_q.push_back(mk($urandom_range(64), 1'b1, 1'b0));
      end
      run(40000);
      chk("rand_tlast_cnt", 64'(tlast_cnt), 64'd200);
      chk("rand_byte_cnt", 64'(out_bytes.size()), 64'(in_bytes.size()));
      if (out_bytes.size() == in_bytes.size())
         for (int i = 0; i < in_bytes.size(); i++) chk("rand_byte", 64'(out_bytes[i]), 64'(in_bytes[i]));

      // asynchronous reset while lane 3 is presented
      vpct = 100; rpct = 100;
      src_q.push_back(mk(64, 1'b1, 1'b0));
      n = 0;
      while (exp_q.size() != 5 && n < 20) begin step(); n++; end
      chk("mid_reach_lane3", 64'(exp_q.size()), 64'd5);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(o_tvalid_out), 64'd0);
      chk("arst_tdata", o_tdata_out, 64'd0);
      chk("arst_tkeep", 64'(o_tkeep_out), 64'd0);
      chk("arst_tlast", 64'(o_tlast_out), 64'd0);
      chk("arst_tready", 64'(o_tready_in), 64'd0);
      exp_q.delete(); src_q.delete(); hold_v = 1'b0; i_tvalid_in = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      log_q.delete();
      src_q.push_back(mk(1, 1'b1, 1'b0));
      run(20);
      repeat (3) step();
      chk("post_rst_count", 64'(log_q.size()), 64'd1);
      if (log_q.size() == 1) begin
         chk("post_rst_keep", 64'(log_q[0].k), 64'h01);
         chk("post_rst_last", 64'(log_q[0].l), 64'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/packet_split.md
# packet_split

Width-down converter for the SHA-1 message path: accepts 512-bit AXI-Stream beats with a byte-enable keep and emits the same bytes, in order, as 64-bit beats with an 8-bit keep. It undoes 512-bit block packing. It sits between a 512-bit producer and a 64-bit consumer, for example a narrow DMA or debug port. Empty 64-bit lanes of a partial last beat are never emitted.

## Interface
- `clk`: input, 1 bit. Single clock; all logic on its rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `o_tready_in`: output, 1 bit. Input ready.
- `i_tvalid_in`: input, 1 bit. Input valid.
- `i_tdata_in`: input, 512 bits. Byte i occupies bits [8i+7:8i]; byte 0 is first in the message.
- `i_tkeep_in`: input, 64 bits. Bit i set means byte i is valid.
- `i_tlast_in`: input, 1 bit. Last beat of a packet.
- `i_tready_out`: input, 1 bit. Downstream ready.
- `o_tvalid_out`: output, 1 bit. Output valid.
- `o_tdata_out`: output, 64 bits. Lane k carries input bytes 8k..8k+7.
- `o_tkeep_out`: output, 8 bits. Keep bits 8k..8k+7 of the held beat.
- `o_tlast_out`: output, 1 bit. Marks the final emitted lane of a packet.

## Operation
- Input keep contract:
  - Non-last beats carry all 64 bits of keep set.
  - A last beat carries a contiguous keep from bit 0, of the form 2^n−1 with n in 0..64.
  - The block does not check this contract; behaviour on violation is undefined beyond keeping the handshakes legal.
- Holding register: one 512-bit data word, 64-bit keep, last flag, and a `busy` flag.
- Per held beat:
  - Lane count L = ceil(popcount(keep)/8), minimum 1.
  - A 3-bit lane index `idx` counts 0..L−1.
- Two states: IDLE (busy=0) and SEND (busy=1).
- IDLE → SEND on an input handshake. The beat is captured, idx=0, and L is computed from i_tkeep_in at capture time.
- In SEND:
  - o_tvalid_out is 1.
  - Output = lane idx of the held beat.
  - o_tlast_out = held_last AND (idx == L−1).
- On an output handshake with idx < L−1: idx increments.
- On an output handshake with idx == L−1:
  - If an input handshake also occurs in the same cycle, the new beat is loaded, idx=0, and the state stays SEND. There is no bubble.
  - Otherwise the state returns to IDLE.
- o_tready_in is combinational: high when !busy, or when (o_tvalid_out AND i_tready_out AND idx == L−1). It is forced 0 while reset_n is low.
- Zero-length last beat (tlast=1, keep=0): one output lane is emitted with o_tkeep_out=0x00, o_tlast_out=1 and o_tdata_out = lane 0 of the data.
- Partial last lane: o_tkeep_out carries the partial mask, e.g. 0x07 for 3 bytes. The data bytes in the unkept positions are passed through unmodified.
- Backpressure: the outputs hold stable while o_tvalid_out=1 and i_tready_out=0. o_tvalid_out never drops without a handshake.
- Packets have no other framing state. Back-to-back packets need no gap.

## Timing
- Reset values: o_tvalid_out=0, o_tdata_out=0, o_tkeep_out=0, o_tlast_out=0, o_tready_in=0, busy=0, idx=0.
- Reset mid-packet drops the held beat immediately. No output beat or tlast is generated after release.
- Latency: a beat accepted at edge N appears on the output in the cycle after edge N, i.e. one register stage.
- Throughput:
  - A full beat occupies 8 output cycles.
  - A last beat with n bytes occupies max(1, ceil(n/8)) cycles.
  - With i_tready_out held at 1 and input always valid, o_tvalid_out stays 1 continuously.
- The output data, keep and last are registered or derived only from registered state. There is no combinational path from the i_* inputs to the o_tdata_out, o_tkeep_out or o_tlast_out outputs.
- o_tready_in has a combinational path from i_tready_out only.

## Test plan
- Single full beat, data bytes 0x00..0x3F, keep all-ones, tlast=1, sink always ready:
  - 8 output beats.
  - Beat 0 data = 0x0706050403020100 and keep 0xFF.
  - Beat 7 data = 0x3F3E3D3C3B3A3938 with tlast=1.
  - tlast=0 on beats 0..6.
- Two-beat packet: a full beat, then a last beat with keep = 2^13−1 (13 bytes):
  - 10 output beats.
  - Beat 8 keep 0xFF.
  - Beat 9 keep 0x1F with tlast=1.
  - o_tvalid_out stays continuously high, with no gap between the input beats.
- Zero-length last beat (keep=0, tlast=1) after a full non-last beat:
  - 9 output beats.
  - The final beat has keep 0x00 and tlast=1.
- Random i_tready_out (50%) over 200 random-length packets:
  - The output byte stream, filtered by keep, equals the input byte stream.
  - tlast count equals the packet count.
  - The outputs stay stable while stalled.
- reset_n asserted asynchronously mid-packet at lane 3:
  - All outputs read 0 before the next edge.
  - After release, a new 1-byte packet yields exactly one beat with keep 0x01 and tlast=1.
- Simultaneous last-lane output handshake and new input handshake:
  - The first lane of the new beat appears in the very next cycle.
  - No lane is duplicated or dropped.
